svf_coeff_gen: RTL and testbench
================================

// Module: svf_coeff_gen
// PURPOSE
//  Control-side producer for the pipelined state-variable filter: turns a normalised
//  cutoff x = Fc/Fs and a resonance r into the filter's F (1.17) and Q1 (2.16).
//  Uses one shared 18x18 signed multiplier, evaluated sequentially:
//  F = 2*sin(pi*x) ~= 2*th*(1 - t/6*(1 - t/20)), with th = pi*x and t = th^2.
//  Q1 = 2 - 2*r. New coefficients reach the filter only on a sample_clk rising edge,
//  so one filter sample never sees a mixed F/Q1 pair.
// PARAMETERS
//  X_MAX    18'd32768   largest accepted x code (0.25 in 0.17); larger requests clamp to it
//  Q1_MIN   18'sh00400  lower bound on Q1 (2.16); limits resonance to keep the filter stable
//  F_RESET  18'sd0      F value driven from reset
//  Q1_RESET 18'sh1FFFF  Q1 value driven from reset (~2.0, i.e. Q=0.5)
// PORTS
//  clk         in   1   system clock; same clock as the filter
//  rst_n       in   1   asynchronous active-low reset
//  sample_clk  in   1   sample strobe (level) shared with the filter; synchronous to clk
//  coef_valid  in   1   request to compute new coefficients
//  coef_ready  out  1   high when a request can be accepted
//  fc_x        in   18  normalised cutoff x, unsigned 0.17 (bit 17 ignored)
//  res         in   16  resonance r, unsigned 0.16
//  F           out  18  signed 1.17 frequency coefficient to the filter
//  Q1          out  18  signed 2.16 damping coefficient to the filter
//  update      out  1   one-cycle pulse in the cycle F/Q1 change
// BEHAVIOUR
//  Reset (async, any state): F=F_RESET, Q1=Q1_RESET, update=0, coef_ready=1, FSM=IDLE.
//   Any calculation in flight is discarded. prev_sample_clk resets to 0.
//  Handshake: request accepted on a clk edge with coef_valid & coef_ready. In that cycle
//   fc_x is latched, clamped to X_MAX, and res is latched. coef_ready then drops and
//   stays low until the cycle after commit. coef_valid while coef_ready=0 is ignored.
//  FSM: IDLE -> THETA -> SQ -> U -> W -> Y -> S -> HOLD -> IDLE.
//   Operands are registered one state ahead; each state captures mul_out.
//   All products are truncated with >>>16 and kept as 18-bit 2.16 unless noted.
//   THETA: th = (x * PI_3Q15) >>> 16        (0.17 * 3.15 -> 2.16)
//   SQ:    t  = (th * th) >>> 16
//   U:     v  = ONE - ((t * C20) >>> 16)
//   W:     w  = (t * C6) >>> 16
//   Y:     z  = ONE - ((w * v) >>> 16)
//   S:     s  = (th * z) >>> 16
//          F_next = s << 2, saturated to 18'h1FFFF
//          Q1_next = max(Q1_MIN, min(18'h1FFFF, 18'h20000 - 2*r)), with 2*r zero-extended
//  HOLD: waits. In the first clk cycle in HOLD where !prev_sample_clk && sample_clk,
//   F<=F_next, Q1<=Q1_next, update<=1, then go to IDLE.
//   A rising edge seen in S or earlier is not used; the next edge is awaited.
//  Latency: accept at cycle 0; HOLD entered at cycle 7. Commit at the first sample edge
//   after that. coef_ready is 1 in the cycle after update.
//  F and Q1 change only in commit cycles. update=0 in every other cycle.
//  x=0 gives F=0 exactly. Arithmetic is signed; intermediates never exceed 2.16 range for x<=X_MAX.
// STRUCTURE
//  Shared package svf_pkg: PI_3Q15=18'sd102944, C6=18'sd10923, C20=18'sd3277,
//   ONE=18'sd65536, state enum (IDLE..HOLD), F_MAX=18'sh1FFFF.
//  Sub-module: reuse the existing smul_18x18 as the single multiplier instance.
//  Sample-edge detector is one flop (prev_sample_clk) plus a gate, inline.
// TESTING
//  1. Reset, no request -> F=0, Q1=18'h1FFFF, coef_ready=1, update never pulses.
//  2. fc_x=0, res=0 -> on first sample edge after HOLD: F=0, Q1=18'h1FFFF, update=1 for one cycle.
//  3. fc_x=10923 (x=1/12), res=16'h8000 -> F=67843 +/-8 LSB, Q1=18'h10000; update 1 cycle.
//  4. fc_x=32768, then fc_x=60000 (clamped) -> F saturates to 18'h1FFFF in both cases; res=16'hFFFF -> Q1=Q1_MIN.
//  5. Pulse sample_clk at accept+3 and accept+20 -> no commit at +3; commit at the +20 edge only.
//     coef_valid held high throughout is ignored until coef_ready returns.
//  6. Assert rst_n=0 during W -> F/Q1 go to reset values immediately; no update pulse;
//     after release, a fresh request completes normally.

Source files
------------

// File: rtl/svf_pkg.sv
// ---------------------------------------------------------------------------
// svf_pkg
//   Shared constants, state encoding and helpers for the state-variable-filter
//   coefficient generator.
//   Fixed-point formats:
//     x      unsigned 0.17
//     PI     3.15
//     th..s  signed 2.16
//     F      signed 1.17
//     Q1     signed 2.16
// ---------------------------------------------------------------------------
package svf_pkg;

  localparam logic signed [17:0] PI_3Q15 = 18'sd102944;  // pi in 3.15
  localparam logic signed [17:0] C6      = 18'sd10923;   // 1/6 in 2.16
  localparam logic signed [17:0] C20     = 18'sd3277;    // 1/20 in 2.16
  localparam logic signed [17:0] ONE     = 18'sd65536;   // 1.0 in 2.16
  localparam logic signed [17:0] F_MAX   = 18'sh1FFFF;   // largest 1.17 value
  localparam logic signed [17:0] F_MIN   = 18'sh20000;   // most negative 1.17 value
  localparam logic [17:0]        Q1_MAX  = 18'h1FFFF;    // ~2.0 in 2.16

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    THETA = 3'd1,
    SQ    = 3'd2,
    U     = 3'd3,
    W     = 3'd4,
    Y     = 3'd5,
    S     = 3'd6,
    HOLD  = 3'd7
  } state_t;

  // s is sin(pi*x) in 2.16; F = 2*s in 1.17 is s shifted left by two.
  // Anything that does not fit in 1.17 is pinned to the rail.
  function automatic logic signed [17:0] sat_f(input logic signed [17:0] s);
    logic signed [17:0] r;
    if (s > 18'sd32767) begin
      r = F_MAX;
    end else if (s < -18'sd32768) begin
      r = F_MIN;
    end else begin
      r = s <<< 2;
    end
    return r;
  endfunction

endpackage

// File: rtl/smul_18x18.sv
// ---------------------------------------------------------------------------
// smul_18x18
//   Combinational 18x18 signed multiplier; the full 36-bit product is
//   returned and the caller selects the bits it needs.
// Ports:
//   i_a  in  18  signed operand A
//   i_b  in  18  signed operand B
//   o_p  out 36  signed product A*B
// ---------------------------------------------------------------------------
module smul_18x18 (
  input  logic signed [17:0] i_a,
  input  logic signed [17:0] i_b,
  output logic signed [35:0] o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/svf_coeff_gen.sv
// ---------------------------------------------------------------------------
// svf_coeff_gen
//   Computes the state-variable-filter coefficients
//     F  = 2*sin(pi*x) ~= 2*th*(1 - t/6*(1 - t/20)),  th = pi*x, t = th^2
//     Q1 = 2 - 2*r  (clamped to [Q1_MIN, ~2.0])
//   using one shared multiplier, one product per state. The result is held
//   until a rising edge of sample_clk so the filter never sees a mixed pair.
// Ports:
//   clk         in   1   system clock (same as the filter)
//   rst_n       in   1   asynchronous active-low reset
//   sample_clk  in   1   sample strobe level, synchronous to clk
//   coef_valid  in   1   request to compute new coefficients
//   coef_ready  out  1   high when a request can be accepted
//   fc_x        in  18   cutoff x, unsigned 0.17 (bit 17 ignored)
//   res         in  16   resonance r, unsigned 0.16
//   F           out 18   signed 1.17 frequency coefficient
//   Q1          out 18   signed 2.16 damping coefficient
//   update      out  1   one-cycle pulse in the cycle F/Q1 change
//
//   state | meaning
//   IDLE  | ready; on accept load x*PI operands
//   THETA | capture th = pi*x
//   SQ    | capture t = th^2
//   U     | capture v = 1 - t/20
//   W     | w = t/6 (fed straight to the multiplier with v)
//   Y     | z = 1 - w*v (fed straight to the multiplier with th)
//   S     | s = th*z; latch F_next and Q1_next
//   HOLD  | wait for a sample_clk rising edge, then commit
// ---------------------------------------------------------------------------
module svf_coeff_gen
  import svf_pkg::*;
#(
  parameter logic [17:0]        X_MAX    = 18'd32768,
  parameter logic signed [17:0] Q1_MIN   = 18'sh00400,
  parameter logic signed [17:0] F_RESET  = 18'sd0,
  parameter logic signed [17:0] Q1_RESET = 18'sh1FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_clk,
  input  logic        coef_valid,
  output logic        coef_ready,
  input  logic [17:0] fc_x,
  input  logic [15:0] res,
  output logic [17:0] F,
  output logic [17:0] Q1,
  output logic        update
);

  state_t r_state;
  state_t w_next_state;

  logic signed [17:0] r_op_a;
  logic signed [17:0] r_op_b;
  logic signed [17:0] w_op_a;
  logic signed [17:0] w_op_b;
  logic signed [35:0] w_mul;
  logic signed [17:0] w_prod;

  logic signed [17:0] r_th;
  logic signed [17:0] r_t;
  logic signed [17:0] r_v;
  logic signed [17:0] r_f_next;
  logic [17:0]        r_q1_next;
  logic [15:0]        r_res;

  logic               r_prev_sample_clk;
  logic               w_sample_rise;
  logic               w_commit;

  logic [17:0]        w_x_req;
  logic [17:0]        w_x_clamped;
  logic [18:0]        w_q1_diff;
  logic [17:0]        w_q1_calc;
  logic               w_unused_bits;

  // ---------------------------------------------------------------------
  // Shared multiplier; every product is truncated 2.16 (>>>16, low 18 bits)
  // ---------------------------------------------------------------------
  smul_18x18 u_mul (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_mul)
  );

  assign w_prod = w_mul[33:16];

  // Bits that are intentionally dropped by the truncation and input format.
  assign w_unused_bits = ^{w_mul[35:34], w_mul[15:0], fc_x[17]};

  assign w_x_req     = {1'b0, fc_x[16:0]};
  assign w_x_clamped = (w_x_req > X_MAX) ? X_MAX : w_x_req;

  // Q1 = 2 - 2r, computed unsigned in 19 bits so 2.0 itself is representable
  // before being clamped into the 2.16 output range.
  always_comb begin
    w_q1_diff = 19'h20000 - {2'b00, r_res, 1'b0};
    if (w_q1_diff > {1'b0, Q1_MAX}) begin
      w_q1_calc = Q1_MAX;
    end else if (w_q1_diff < {1'b0, Q1_MIN}) begin
      w_q1_calc = Q1_MIN;
    end else begin
      w_q1_calc = w_q1_diff[17:0];
    end
  end

  // Edges that occur before HOLD are deliberately not remembered: only an
  // edge observed while already in HOLD commits.
  assign w_sample_rise = sample_clk & ~r_prev_sample_clk;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (coef_valid) w_next_state = THETA;
      THETA:   w_next_state = SQ;
      SQ:      w_next_state = U;
      U:       w_next_state = W;
      W:       w_next_state = Y;
      Y:       w_next_state = S;
      S:       w_next_state = HOLD;
      HOLD:    if (w_sample_rise) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and operand selection for the next multiply
  // ---------------------------------------------------------------------
  always_comb begin
    coef_ready = 1'b0;
    w_commit   = 1'b0;
    w_op_a     = r_op_a;
    w_op_b     = r_op_b;
    case (r_state)
      IDLE: begin
        coef_ready = 1'b1;
        if (coef_valid) begin
          w_op_a = $signed(w_x_clamped);
          w_op_b = PI_3Q15;
        end
      end
      THETA: begin
        w_op_a = w_prod;
        w_op_b = w_prod;
      end
      SQ: begin
        w_op_a = w_prod;
        w_op_b = C20;
      end
      U: begin
        w_op_a = r_t;
        w_op_b = C6;
      end
      W: begin
        w_op_a = w_prod;
        w_op_b = r_v;
      end
      Y: begin
        w_op_a = r_th;
        w_op_b = ONE - w_prod;
      end
      HOLD: begin
        w_commit = w_sample_rise;
      end
      default: begin
        w_op_a = r_op_a;
        w_op_b = r_op_b;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a            <= '0;
      r_op_b            <= '0;
      r_th              <= '0;
      r_t               <= '0;
      r_v               <= '0;
      r_f_next          <= '0;
      r_q1_next         <= '0;
      r_res             <= '0;
      r_prev_sample_clk <= 1'b0;
    end else begin
      r_op_a            <= w_op_a;
      r_op_b            <= w_op_b;
      r_prev_sample_clk <= sample_clk;
      case (r_state)
        IDLE:  if (coef_valid) r_res <= res;
        THETA: r_th <= w_prod;
        SQ:    r_t  <= w_prod;
        U:     r_v  <= ONE - w_prod;
        S: begin
          r_f_next  <= sat_f(w_prod);
          r_q1_next <= w_q1_calc;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Coefficient outputs; only ever change together with update
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F      <= F_RESET;
      Q1     <= Q1_RESET;
      update <= 1'b0;
    end else begin
      update <= w_commit;
      if (w_commit) begin
        F  <= r_f_next;
        Q1 <= r_q1_next;
      end
    end
  end

endmodule

// File: tb/tb_svf_coeff_gen.sv
// ---------------------------------------------------------------------------
// tb_svf_coeff_gen
//   Self-checking bench for svf_coeff_gen: directed vector table, corner-case
//   sequences (reset mid-calculation, early sample edges, held coef_valid)
//   and randomized requests compared against a fixed-point reference model.
// ---------------------------------------------------------------------------
module tb_svf_coeff_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_clk;
  logic        coef_valid;
  logic        coef_ready;
  logic [17:0] fc_x;
  logic [15:0] res;
  logic [17:0] F;
  logic [17:0] Q1;
  logic        update;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  int viol     = 0;

  logic [17:0] p_f;
  logic [17:0] p_q1;
  logic        p_upd   = 1'b0;
  logic        p_valid = 1'b0;

  always #5 clk = ~clk;

  svf_coeff_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_clk (sample_clk),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .fc_x       (fc_x),
    .res        (res),
    .F          (F),
    .Q1         (Q1),
    .update     (update)
  );

  always @(posedge clk) begin
    if (update) upd_cnt <= upd_cnt + 1;
  end

  // F/Q1 may only move in an update cycle, and update is a single-cycle pulse.
  always @(negedge clk) begin
    if (rst_n && p_valid) begin
      if (((F != p_f) || (Q1 != p_q1)) && !update) viol <= viol + 1;
      else if (update && p_upd) viol <= viol + 1;
    end
    p_f     <= F;
    p_q1    <= Q1;
    p_upd   <= update;
    p_valid <= rst_n;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Reference model: the specified fixed-point recurrence in plain integers
  // -------------------------------------------------------------------------
  function automatic int ref_f(input logic [17:0] fx);
    longint x, th, t, v, w, z, s, f;
    x = longint'(fx[16:0]);
    if (x > 32768) x = 32768;
    th = (x * 102944) >>> 16;
    t  = (th * th) >>> 16;
    v  = 65536 - ((t * 3277) >>> 16);
    w  = (t * 10923) >>> 16;
    z  = 65536 - ((w * v) >>> 16);
    s  = (th * z) >>> 16;
    f  = s * 4;
    if (f > 131071) f = 131071;
    return int'(f);
  endfunction

  function automatic int ref_q1(input logic [15:0] r);
    longint q;
    q = 131072 - 2 * longint'(r);
    if (q > 131071) q = 131071;
    if (q < 1024) q = 1024;
    return int'(q);
  endfunction

  // Commit happens at the first sampled rising edge at or after cycle 7.
  function automatic int ref_edge(input logic [63:0] mask);
    for (int k = 7; k < 64; k++) begin
      if (mask[k] && !mask[k-1]) return k;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp,
                           input longint tol);
    longint d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // One request: accept at edge 0, then sample_clk(k) = mask[k] for edge k.
  task automatic run_vec(input string name, input logic [17:0] x, input logic [15:0] r,
                         input logic [63:0] mask, input int exp_edge, input int exp_f,
                         input int exp_q1, input int tol, input bit hold_valid);
    int waited;
    int seen;
    waited = 0;
    seen   = -1;
    sample_clk = 1'b0;
    while (!coef_ready && waited < 50) begin
      tick;
      waited++;
    end
    if (!coef_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_wait: got coef_ready=0 expected 1 within 50 cycles", name);
      return;
    end
    fc_x       = x;
    res        = r;
    coef_valid = 1'b1;
    tick;
    check({name, "_busy"}, coef_ready, 0);
    if (hold_valid) begin
      fc_x = 18'($urandom);
      res  = 16'($urandom);
    end else begin
      coef_valid = 1'b0;
    end
    for (int k = 1; k < 64; k++) begin
      sample_clk = mask[k];
      tick;
      if (update) begin
        seen = k;
        break;
      end
    end
    coef_valid = 1'b0;
    sample_clk = 1'b0;
    check({name, "_edge"}, seen, exp_edge);
    check_tol({name, "_F"}, $signed(F), exp_f, tol);
    check({name, "_Q1"}, Q1, exp_q1);
    tick;
    check({name, "_upd_low"}, update, 0);
    check({name, "_ready"}, coef_ready, 1);
  endtask

  typedef struct {
    string       name;
    logic [17:0] x;
    logic [15:0] r;
    logic [63:0] mask;
    int          exp_edge;
    int          exp_f;
    int          exp_q1;
    int          tol;
    bit          hold_valid;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int   upd0;

    vecs[0] = '{"zero",      18'd0,      16'h0000, 64'h0000_0C00,   10, 0,      131071, 0, 1'b0};
    vecs[1] = '{"x12",       18'd10923,  16'h8000, 64'h0000_0C00,   10, 67843,  65536,  8, 1'b0};
    vecs[2] = '{"xmax",      18'd32768,  16'hFFFF, 64'h0000_0080,   7,  131071, 1024,   0, 1'b0};
    vecs[3] = '{"zero_b",    18'd0,      16'h4000, 64'h0000_0080,   7,  0,      98304,  0, 1'b0};
    vecs[4] = '{"xclamp",    18'd60000,  16'hFFFF, 64'h0000_11C0,   12, 131071, 1024,   0, 1'b0};
    vecs[5] = '{"bit17",     18'h22AAB,  16'h8000, 64'h0030_0018,   20, 67843,  65536,  8, 1'b1};
    vecs[6] = '{"late_edge", 18'd10923,  16'h0000, 64'h0030_0018,   20, 67843,  131071, 8, 1'b1};

    rst_n      = 1'b0;
    sample_clk = 1'b0;
    coef_valid = 1'b0;
    fc_x       = '0;
    res        = '0;
    #23;
    check("rst_F", F, 0);
    check("rst_Q1", Q1, 131071);
    check("rst_ready", coef_ready, 1);
    check("rst_update", update, 0);
    rst_n = 1'b1;

    // Idle with sample edges but no request: nothing may change.
    for (int i = 0; i < 30; i++) begin
      sample_clk = ((i % 6) < 2);
      tick;
    end
    sample_clk = 1'b0;
    check("idle_updates", upd_cnt, 0);
    check("idle_F", F, 0);
    check("idle_Q1", Q1, 131071);
    check("idle_ready", coef_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].name, vecs[i].x, vecs[i].r, vecs[i].mask, vecs[i].exp_edge,
              vecs[i].exp_f, vecs[i].exp_q1, vecs[i].tol, vecs[i].hold_valid);
    end

    // Reset asserted while the FSM is in W.
    run_vec("pre_rst", 18'd32768, 16'hFFFF, 64'h0000_0080, 7, 131071, 1024, 0, 1'b0);
    upd0       = upd_cnt;
    fc_x       = 18'd10923;
    res        = 16'h0000;
    coef_valid = 1'b1;
    tick;
    coef_valid = 1'b0;
    tick;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("midrst_F", F, 0);
    check("midrst_Q1", Q1, 131071);
    check("midrst_ready", coef_ready, 1);
    check("midrst_update", update, 0);
    for (int i = 0; i < 4; i++) begin
      sample_clk = i[0];
      tick;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample_clk = ((i % 4) < 2);
      tick;
    end
    sample_clk = 1'b0;
    check("midrst_no_upd", upd_cnt, upd0);
    check("midrst_F_held", F, 0);
    run_vec("post_rst", 18'd10923, 16'h8000, 64'h0000_0C00, 10, 67843, 65536, 8, 1'b0);

    // Randomized requests against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [63:0] mask;
      logic [17:0] x;
      logic [15:0] r;
      int p1, w1, p2, w2;
      p1 = $urandom_range(1, 20);
      w1 = $urandom_range(1, 3);
      p2 = p1 + w1 + 1 + $urandom_range(0, 10);
      if (p2 < 8) p2 = 8 + $urandom_range(0, 5);
      w2 = $urandom_range(1, 3);
      mask = '0;
      for (int i = p1; i < p1 + w1; i++) mask[i] = 1'b1;
      for (int i = p2; i < p2 + w2; i++) mask[i] = 1'b1;
      x = 18'($urandom_range(0, 40000));
      if (n % 5 == 0) x = 18'($urandom);
      r = 16'($urandom);
      run_vec($sformatf("rnd%0d", n), x, r, mask, ref_edge(mask), ref_f(x), ref_q1(r), 0,
              bit'($urandom_range(0, 1)));
    end

    tick;
    check("no_stray_change", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
